// File: rtl/alu_result_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_buffer_if
//  Description : Bundles the ALU unit result/flag inputs, the read handshake
//                and the FIFO status outputs of alu_result_buffer.
//                master = the unit/reader side, slave = the buffer itself.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals (direction seen from the buffer):
//    i_arith_out/i_logic_out/i_cmp_out/i_shift_out  in   unit results
//    i_arith_flag/i_logic_flag/i_cmp_flag/i_shift_flag in unit result valid
//    i_rd_en      in   read request
//    i_clr_err    in   clear sticky error flags
//    o_rd_data    out  popped result
//    o_rd_unit    out  unit tag of popped result (00 A, 01 L, 10 C, 11 S)
//    o_rd_valid   out  one-cycle pulse per pop
//    o_empty/o_full/o_count  out  occupancy status
//    o_overflow/o_multi_err  out  sticky errors
// ============================================================================
interface alu_result_buffer_if #(
  parameter int IN_OUT = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IN_OUT-1:0] i_arith_out;
  logic [IN_OUT-1:0] i_logic_out;
  logic [IN_OUT-1:0] i_cmp_out;
  logic [IN_OUT-1:0] i_shift_out;
  logic              i_arith_flag;
  logic              i_logic_flag;
  logic              i_cmp_flag;
  logic              i_shift_flag;
  logic              i_rd_en;
  logic              i_clr_err;
  logic [IN_OUT-1:0] o_rd_data;
  logic [1:0]        o_rd_unit;
  logic              o_rd_valid;
  logic              o_empty;
  logic              o_full;
  logic [CW-1:0]     o_count;
  logic              o_overflow;
  logic              o_multi_err;

  modport master (
    output i_arith_out, i_logic_out, i_cmp_out, i_shift_out,
    output i_arith_flag, i_logic_flag, i_cmp_flag, i_shift_flag,
    output i_rd_en, i_clr_err,
    input  o_rd_data, o_rd_unit, o_rd_valid, o_empty, o_full, o_count,
    input  o_overflow, o_multi_err
  );

  modport slave (
    input  i_arith_out, i_logic_out, i_cmp_out, i_shift_out,
    input  i_arith_flag, i_logic_flag, i_cmp_flag, i_shift_flag,
    input  i_rd_en, i_clr_err,
    output o_rd_data, o_rd_unit, o_rd_valid, o_empty, o_full, o_count,
    output o_overflow, o_multi_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_buffer
//  Description : Collects the flagged ALU unit result each cycle (fixed
//                priority Arith > Logic > CMP > Shift), tags it with a unit
//                ID and pushes it into a circular FIFO drained by a
//                read-enable handshake. Sticky Overflow / Multi_Err flags.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk  in   clock, all state on posedge
//    rst  in   asynchronous active-high reset
//    bus  slave modport of alu_result_buffer_if (results, flags, read
//         handshake, FIFO status and error outputs)
// ============================================================================
module alu_result_buffer #(
  parameter int IN_OUT = 16,
  parameter int DEPTH  = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  alu_result_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = IN_OUT + 2;
  localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);

  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [IN_OUT-1:0] r_rd_data;
  logic [1:0]        r_rd_unit;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_multi_err;

  logic              w_wr;
  logic              w_multi;
  logic [IN_OUT-1:0] w_sel_data;
  logic [1:0]        w_sel_unit;
  logic              w_empty;
  logic              w_full;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_drop;

  assign w_wr = bus.i_arith_flag | bus.i_logic_flag | bus.i_cmp_flag | bus.i_shift_flag;

  // Any pair of flags high at once.
  assign w_multi = (bus.i_arith_flag & bus.i_logic_flag) |
                   (bus.i_arith_flag & bus.i_cmp_flag)   |
                   (bus.i_arith_flag & bus.i_shift_flag) |
                   (bus.i_logic_flag & bus.i_cmp_flag)   |
                   (bus.i_logic_flag & bus.i_shift_flag) |
                   (bus.i_cmp_flag   & bus.i_shift_flag);

  always_comb begin
    w_sel_data = '0;
    w_sel_unit = 2'b00;
    if (bus.i_arith_flag) begin
      w_sel_data = bus.i_arith_out;
      w_sel_unit = 2'b00;
    end else if (bus.i_logic_flag) begin
      w_sel_data = bus.i_logic_out;
      w_sel_unit = 2'b01;
    end else if (bus.i_cmp_flag) begin
      w_sel_data = bus.i_cmp_out;
      w_sel_unit = 2'b10;
    end else if (bus.i_shift_flag) begin
      w_sel_data = bus.i_shift_out;
      w_sel_unit = 2'b11;
    end
  end

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_FULL_CNT);
  assign w_rd_acc = bus.i_rd_en & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr_acc = w_wr & (~w_full | w_rd_acc);
  assign w_drop   = w_wr & w_full & ~w_rd_acc;

  // Storage needs no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= {w_sel_unit, w_sel_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_unit   <= 2'b00;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        {r_rd_unit, r_rd_data} <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + CW'(1);
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - CW'(1);
      end
      // Set has priority over clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.i_clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_multi) begin
        r_multi_err <= 1'b1;
      end else if (bus.i_clr_err) begin
        r_multi_err <= 1'b0;
      end
    end
  end

  assign bus.o_rd_data   = r_rd_data;
  assign bus.o_rd_unit   = r_rd_unit;
  assign bus.o_rd_valid  = r_rd_valid;
  assign bus.o_empty     = w_empty;
  assign bus.o_full      = w_full;
  assign bus.o_count     = r_count;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_multi_err = r_multi_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_buffer
//  Description : Self-checking bench for alu_result_buffer. A queue-based
//                reference model predicts every output after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_buffer;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_result_buffer_if #(.IN_OUT(W), .DEPTH(DEPTH)) bus ();

  alu_result_buffer #(.IN_OUT(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]   u;
    logic [W-1:0] d;
  } ent_t;

  typedef struct {
    logic [3:0]   fl;   // {shift, cmp, logic, arith}
    logic [W-1:0] a, l, c, s;
    logic [1:0]   exp_unit;
    logic [W-1:0] exp_data;
    logic         exp_multi;
  } vec_t;

  ent_t         q[$];
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   m_unit;
  logic         m_ovf;
  logic         m_multi;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_valid",  32'(bus.o_rd_valid),  32'(m_valid));
    chk("rd_data",   32'(bus.o_rd_data),   32'(m_data));
    chk("rd_unit",   32'(bus.o_rd_unit),   32'(m_unit));
    chk("count",     32'(bus.o_count),     32'(q.size()));
    chk("empty",     32'(bus.o_empty),     32'(q.size() == 0));
    chk("full",      32'(bus.o_full),      32'(q.size() == DEPTH));
    chk("overflow",  32'(bus.o_overflow),  32'(m_ovf));
    chk("multi_err", 32'(bus.o_multi_err), 32'(m_multi));
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_unit  = 2'b00;
    m_ovf   = 1'b0;
    m_multi = 1'b0;
  endtask

  task automatic idle();
    bus.i_arith_flag = 1'b0; bus.i_logic_flag = 1'b0;
    bus.i_cmp_flag   = 1'b0; bus.i_shift_flag = 1'b0;
    bus.i_arith_out  = '0;   bus.i_logic_out  = '0;
    bus.i_cmp_out    = '0;   bus.i_shift_out  = '0;
    bus.i_rd_en      = 1'b0; bus.i_clr_err    = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict, clock, compare everything.
  task automatic step(input logic [3:0] fl, input logic [W-1:0] a, l, c, s,
                      input logic rd, input logic clr);
    ent_t e;
    bit   pop, push;
    int   n;
    bus.i_arith_flag = fl[0]; bus.i_logic_flag = fl[1];
    bus.i_cmp_flag   = fl[2]; bus.i_shift_flag = fl[3];
    bus.i_arith_out  = a; bus.i_logic_out = l;
    bus.i_cmp_out    = c; bus.i_shift_out = s;
    bus.i_rd_en      = rd; bus.i_clr_err = clr;
    n    = $countones(fl);
    pop  = rd && (q.size() != 0);
    push = (n != 0) && ((q.size() < DEPTH) || pop);
    if (fl[0])      e = '{u: 2'd0, d: a};
    else if (fl[1]) e = '{u: 2'd1, d: l};
    else if (fl[2]) e = '{u: 2'd2, d: c};
    else            e = '{u: 2'd3, d: s};
    @(posedge clk);
    #1;
    m_valid = pop;
    if (pop) begin
      ent_t h;
      h = q.pop_front();
      m_unit = h.u;
      m_data = h.d;
    end
    if (push) q.push_back(e);
    if ((n != 0) && !push) m_ovf = 1'b1;
    else if (clr)          m_ovf = 1'b0;
    if (n > 1)             m_multi = 1'b1;
    else if (clr)          m_multi = 1'b0;
    check_all();
  endtask

  task automatic wr1(input logic [3:0] fl, input logic [W-1:0] v);
    step(fl, v, v, v, v, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    step(4'b0000, '0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic clr1();
    step(4'b0000, '0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any edge.
  task automatic mid_reset();
    #2;
    idle();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vec[6];

  initial begin
    vec[0] = '{fl: 4'b1000, a: 16'h0000, l: 16'h0000, c: 16'h0000, s: 16'h0A5A,
               exp_unit: 2'b11, exp_data: 16'h0A5A, exp_multi: 1'b0};
    vec[1] = '{fl: 4'b0101, a: 16'h1111, l: 16'h0000, c: 16'h0001, s: 16'h0000,
               exp_unit: 2'b00, exp_data: 16'h1111, exp_multi: 1'b1};
    vec[2] = '{fl: 4'b0110, a: 16'h0000, l: 16'h2222, c: 16'h3333, s: 16'h0000,
               exp_unit: 2'b01, exp_data: 16'h2222, exp_multi: 1'b1};
    vec[3] = '{fl: 4'b1100, a: 16'h0000, l: 16'h0000, c: 16'h4444, s: 16'h5555,
               exp_unit: 2'b10, exp_data: 16'h4444, exp_multi: 1'b1};
    vec[4] = '{fl: 4'b0010, a: 16'h0000, l: 16'h6666, c: 16'h0000, s: 16'h0000,
               exp_unit: 2'b01, exp_data: 16'h6666, exp_multi: 1'b0};
    vec[5] = '{fl: 4'b1111, a: 16'h7777, l: 16'h8888, c: 16'h9999, s: 16'hAAAA,
               exp_unit: 2'b00, exp_data: 16'h7777, exp_multi: 1'b1};

    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Reset mid-stream with entries stored and a Rd_Valid pending.
    wr1(4'b0001, 16'h00AA);
    wr1(4'b0001, 16'h00BB);
    rd1();
    mid_reset();
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_empty", 32'(bus.o_empty), 32'd1);

    // Single Shift entry.
    wr1(4'b1000, 16'h0A5A);
    rd1();
    chk("single_valid", 32'(bus.o_rd_valid), 32'd1);
    chk("single_data",  32'(bus.o_rd_data),  32'h0A5A);
    chk("single_unit",  32'(bus.o_rd_unit),  32'd3);
    chk("single_empty", 32'(bus.o_empty),    32'd1);

    // Table-driven priority vectors.
    for (int i = 0; i < 6; i++) begin
      step(vec[i].fl, vec[i].a, vec[i].l, vec[i].c, vec[i].s, 1'b0, 1'b0);
      rd1();
      chk("vec_data",  32'(bus.o_rd_data),   32'(vec[i].exp_data));
      chk("vec_unit",  32'(bus.o_rd_unit),   32'(vec[i].exp_unit));
      chk("vec_multi", 32'(bus.o_multi_err), 32'(vec[i].exp_multi));
      clr1();
      chk("vec_clr", 32'(bus.o_multi_err), 32'd0);
    end

    // Fill and overflow.
    for (int i = 1; i <= 5; i++) begin
      wr1(4'b0001, W'(i));
      if (i == 4) chk("fill_full", 32'(bus.o_full), 32'd1);
      if (i == 4) chk("fill_noovf", 32'(bus.o_overflow), 32'd0);
    end
    chk("ovf_set", 32'(bus.o_overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      rd1();
      chk("drain_data", 32'(bus.o_rd_data), 32'(i));
      chk("drain_unit", 32'(bus.o_rd_unit), 32'd0);
    end
    chk("drain_empty", 32'(bus.o_empty), 32'd1);
    clr1();
    chk("ovf_clr", 32'(bus.o_overflow), 32'd0);

    // Simultaneous read/write at Full.
    for (int i = 0; i < 4; i++) wr1(4'b0001, W'(16'h0010 + i));
    step(4'b0010, '0, 16'hBEEF, '0, '0, 1'b1, 1'b0);
    chk("rw_full_count", 32'(bus.o_count),    32'd4);
    chk("rw_full_ovf",   32'(bus.o_overflow), 32'd0);
    for (int i = 0; i < 4; i++) rd1();
    chk("rw_last", 32'(bus.o_rd_data), 32'hBEEF);

    // Set beats clear in the same cycle.
    step(4'b0011, 16'h1, 16'h2, '0, '0, 1'b1, 1'b1);
    chk("set_wins", 32'(bus.o_multi_err), 32'd1);
    rd1();
    clr1();

    // Empty read, then wrap.
    rd1();
    chk("empty_rd_valid", 32'(bus.o_rd_valid), 32'd0);
    chk("empty_rd_count", 32'(bus.o_count),    32'd0);
    for (int i = 0; i < 10; i++) begin
      wr1(4'b0100, W'(16'h0100 + i));
      chk("wrap_cnt", 32'(bus.o_count <= 1), 32'd1);
      rd1();
      chk("wrap_data", 32'(bus.o_rd_data), 32'(16'h0100 + i));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] fl;
      fl = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      if ($urandom_range(0, 2) == 0) fl = 4'b0000;
      step(fl, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0));
      if (i == 200) mid_reset();
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_buffer.md
# alu_result_buffer

Result collector on the consumer side of the ALU unit outputs. Each cycle it samples the registered result/flag pairs of the Arithmetic, Logic, CMP and Shift units, then writes the result of the flagged unit, tagged with a unit ID, into a circular FIFO. A downstream reader drains the FIFO with a read-enable handshake. Sticky error flags report overflow and multiple flagged units.

## Interface
- In_out, 16: result data width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  input  In_out each  unit results.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  input  1 each  the unit's result is valid this cycle.
- Rd_En  input  1  read request.
- Clr_Err  input  1  clears sticky error flags.
- Rd_Data  output  In_out  popped result, registered.
- Rd_Unit  output  2  unit tag of the popped result: 00 Arith, 01 Logic, 10 CMP, 11 Shift.
- Rd_Valid  output  1  Rd_Data/Rd_Unit valid; one-cycle pulse per pop.
- Empty  output  1  FIFO holds 0 entries.
- Full  output  1  FIFO holds DEPTH entries.
- Count  output  clog2(DEPTH)+1  current occupancy.
- Overflow  output  1  sticky: a write was dropped.
- Multi_Err  output  1  sticky: more than one flag was high in the same cycle.

## Operation
- Write request (wr) is high when any input flag is high.
  - Source select is by fixed priority: Arith > Logic > CMP > Shift.
  - Only the selected unit's result and tag are written. Lower-priority results that cycle are discarded.
  - If two or more flags are high, set Multi_Err.
- Storage: DEPTH×(In_out+2) array with write pointer, read pointer and occupancy counter. Pointers are clog2(DEPTH) bits and wrap DEPTH-1 → 0.
- Write is accepted when wr=1 and either Full=0, or Full=1 with a read accepted the same cycle.
- Write dropped (wr=1, Full=1, no accepted read): set Overflow. The array, pointers and Count are unchanged.
- Read is accepted when Rd_En=1 and Empty=0. On an accepted read:
  - Rd_Data and Rd_Unit load the head entry.
  - Rd_Valid goes to 1 for the next cycle.
  - The read pointer advances.
- Rd_En with Empty=1 is ignored. Rd_Valid=0, and Rd_Data/Rd_Unit hold their last values.
- No write-to-read bypass. A write into an empty FIFO becomes readable the cycle after it is written.
- Count update: +1 on write only, −1 on read only, unchanged on simultaneous accepted read and write.
- Empty = (Count==0) and Full = (Count==DEPTH), both decoded from registered Count.
- Error clearing:
  - Clr_Err=1 clears Overflow and Multi_Err on the next edge.
  - If a new error occurs in the same cycle as Clr_Err, set wins.
- Rd_Data, Rd_Unit, Rd_Valid, Overflow, Multi_Err and Count are registers.

## Timing
- Reset (RST=1, asynchronous assert, release on the next edge), all outputs and state:
  - Pointers 0.
  - Count 0, Empty 1, Full 0.
  - Rd_Data 0, Rd_Unit 00, Rd_Valid 0.
  - Overflow 0, Multi_Err 0.
  - Array contents don't-care.
- Reset mid-operation discards all entries and any pending Rd_Valid immediately.
- Write latency: flag sampled at edge N, entry stored at edge N. Empty falls and Count increments after edge N.
- Read latency: Rd_En sampled at edge N (Empty=0), so Rd_Valid=1 with data during cycle N+1.
- Back-to-back: Rd_En held high pops one entry per cycle until Empty. Rd_Valid stays high for exactly as many cycles as there are accepted reads.
- Full throughput: one write and one read every cycle at any occupancy 1..DEPTH with no loss.
- The unit outputs are themselves registered, so flags are sampled directly with no extra synchronising stage.

## Test plan
- Reset and single entry:
  - Assert RST mid-stream → all outputs at reset values, Count=0, Empty=1.
  - Release, then pulse Shift_Flag with Shift_OUT=16'h0A5A, then Rd_En → Rd_Valid=1, Rd_Data=16'h0A5A, Rd_Unit=11, Empty=1 afterwards.
- Fill and overflow:
  - Write 5 consecutive Arith results 16'h0001..16'h0005 with no reads → Full=1 after 4 writes, Overflow=1 after the 5th.
  - Drain → 16'h0001..16'h0004 in order with Rd_Unit=00, then Empty=1.
- Simultaneous read/write at Full: Rd_En and Logic_Flag (16'hBEEF) both high → no Overflow, Count stays 4, BEEF is the last entry popped.
- Priority and Multi_Err:
  - Arith_Flag and CMP_Flag high together with Arith_OUT=16'h1111, CMP_OUT=16'h0001 → single entry 16'h1111 tagged 00, Multi_Err=1.
  - Clr_Err → Multi_Err=0 next cycle.
- Empty read and wrap:
  - Rd_En with Empty=1 → Rd_Valid=0, Count=0.
  - Then 10 write/read pairs with values 16'h0100+i → every value returned in order across pointer wrap, with Count never exceeding 1.
